// File: rtl/drum_speed_ramp.sv
// Drum motor speed shaper: rate-limits the FSM speed command into a motor
// setpoint on a slow tick, backs the ceiling off on vibration and brakes the
// drum to zero (raising a fault) if the door is unlocked while it turns.
module drum_speed_ramp #(
  parameter int unsigned TICK_DIV    = 5,
  parameter int unsigned STEP        = 50,
  parameter int unsigned BRAKE_STEP  = 200,
  parameter int unsigned VIB_BACKOFF = 200,
  parameter int unsigned MAX_RPM     = 1400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] target_rpm,
  input  logic        door_locked,
  input  logic        vibration_sensor,
  output logic [10:0] motor_rpm,
  output logic        at_speed,
  output logic        vib_limited,
  output logic        door_fault,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    AT_SPEED  = 3'd2,
    RAMP_DOWN = 3'd3,
    BRAKE     = 3'd4
  } state_t;

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [11:0] MAX12   = 12'(MAX_RPM);
  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [11:0] BRAKE12 = 12'(BRAKE_STEP);
  localparam logic [11:0] VIB12   = 12'(VIB_BACKOFF);
  localparam logic [10:0] MAX11   = 11'(MAX_RPM);

  function automatic logic [11:0] min2(input logic [11:0] a, input logic [11:0] b);
    return (a < b) ? a : b;
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic [10:0]      limit;
  logic [10:0]      rpm_next;
  logic             tick, braking, vib_event;
  logic [11:0]      rpm12, tgt12, lim12, vib_lim12, lim_tick12, eff12, eff_tick12;

  assign state_dbg = state;

  // Tick strobe, braking/vibration qualification, effective targets and the per-tick speed step.
  // eff_tick12 already uses the lowered ceiling so a vibration tick steps toward the new target.
  always_comb begin
    rpm12      = {1'b0, motor_rpm};
    tgt12      = {1'b0, target_rpm};
    lim12      = {1'b0, limit};
    tick       = (tick_cnt == TICK_LAST);
    braking    = (state == BRAKE) || (!door_locked && (motor_rpm != '0));
    vib_event  = tick && vibration_sensor && (motor_rpm != '0) && !braking;
    vib_lim12  = (rpm12 > VIB12) ? (rpm12 - VIB12) : '0;
    lim_tick12 = vib_event ? vib_lim12 : lim12;
    eff12      = door_locked ? min2(min2(tgt12, MAX12), lim12) : '0;
    eff_tick12 = door_locked ? min2(min2(tgt12, MAX12), lim_tick12) : '0;
    rpm_next   = motor_rpm;
    if (tick) begin
      if (braking)
        rpm_next = 11'(rpm12 - min2(BRAKE12, rpm12));
      else if (eff_tick12 > rpm12)
        rpm_next = 11'(rpm12 + min2(STEP12, eff_tick12 - rpm12));
      else if (eff_tick12 < rpm12)
        rpm_next = 11'(rpm12 - min2(STEP12, rpm12 - eff_tick12));
    end
  end

  // Next-state: BRAKE is sticky until the drum stops; otherwise classify speed vs target.
  always_comb begin
    state_next = state;
    if (state == BRAKE)
      state_next = (motor_rpm == '0) ? IDLE : BRAKE;
    else if (!door_locked && (motor_rpm != '0))
      state_next = BRAKE;
    else if (eff12 > rpm12)
      state_next = RAMP_UP;
    else if (eff12 < rpm12)
      state_next = RAMP_DOWN;
    else if (rpm12 == '0)
      state_next = IDLE;
    else
      state_next = AT_SPEED;
  end

  // State register, tick counter, ceiling and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      limit       <= MAX11;
      motor_rpm   <= '0;
      at_speed    <= 1'b0;
      vib_limited <= 1'b0;
      door_fault  <= 1'b0;
    end else begin
      state       <= state_next;
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      motor_rpm   <= rpm_next;
      at_speed    <= (state_next == AT_SPEED);
      vib_limited <= (limit < MAX11);
      if (vib_event)
        limit <= 11'(vib_lim12);
      else if (tick && (motor_rpm == '0) && (target_rpm == '0))
        limit <= MAX11;
      if (!door_locked && (motor_rpm != '0))
        door_fault <= 1'b1;
      else if (door_locked && (motor_rpm == '0))
        door_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_drum_speed_ramp.sv
// Directed bench for drum_speed_ramp with default parameters.
// Cycle numbers count rising edges after reset release; ticks land on multiples of 5.
module tb_drum_speed_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] target_rpm;
  logic        door_locked;
  logic        vibration_sensor;
  logic [10:0] motor_rpm;
  logic        at_speed;
  logic        vib_limited;
  logic        door_fault;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int now    = 0;

  drum_speed_ramp #(
    .TICK_DIV   (5),
    .STEP       (50),
    .BRAKE_STEP (200),
    .VIB_BACKOFF(200),
    .MAX_RPM    (1400)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .target_rpm       (target_rpm),
    .door_locked      (door_locked),
    .vibration_sensor (vibration_sensor),
    .motor_rpm        (motor_rpm),
    .at_speed         (at_speed),
    .vib_limited      (vib_limited),
    .door_fault       (door_fault),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge number k.
  task automatic goto(input int k);
    while (now < k) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; target_rpm = '0; door_locked = 1'b1; vibration_sensor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rpm", motor_rpm, 0);
    chk("rst_at_speed", at_speed, 0);
    chk("rst_vib", vib_limited, 0);
    chk("rst_fault", door_fault, 0);
    chk("rst_state", state_dbg, 0);

    // Ramp up to 400
    reset = 1'b0; target_rpm = 11'd400; now = 0;
    goto(4);   chk("up_before_tick", motor_rpm, 0);
    goto(5);   chk("up_tick1", motor_rpm, 50);
               chk("up_state", state_dbg, 1);
    goto(39);  chk("up_tick7", motor_rpm, 350);
    goto(40);  chk("up_reach", motor_rpm, 400);
               chk("up_at_speed_lag", at_speed, 0);
    goto(41);  chk("up_at_speed", at_speed, 1);
               chk("up_state_at", state_dbg, 2);

    // Near-target step 400 -> 430
    target_rpm = 11'd430;
    goto(44);  chk("near_hold", motor_rpm, 400);
    goto(45);  chk("near_land", motor_rpm, 430);
    goto(46);  chk("near_at_speed", at_speed, 1);

    // Clamp at 1400
    target_rpm = 11'd1500;
    goto(144); chk("clamp_1380", motor_rpm, 1380);
    goto(145); chk("clamp_1400", motor_rpm, 1400);
    goto(146); chk("clamp_at_speed", at_speed, 1);
               chk("clamp_state", state_dbg, 2);

    // Ramp down to zero in 28 ticks
    target_rpm = 11'd0;
    goto(284); chk("down_50", motor_rpm, 50);
    goto(285); chk("down_0", motor_rpm, 0);
    goto(286); chk("down_idle", state_dbg, 0);
               chk("down_at_speed", at_speed, 0);

    // Ramp to 1200 then vibration backoff
    target_rpm = 11'd1200;
    goto(405); chk("vib_pre_1200", motor_rpm, 1200);
    goto(406); chk("vib_pre_at_speed", at_speed, 1);
    vibration_sensor = 1'b1;
    goto(410); chk("vib_1150", motor_rpm, 1150);
               chk("vib_flag_lag", vib_limited, 0);
    vibration_sensor = 1'b0;
    goto(411); chk("vib_flag", vib_limited, 1);
               chk("vib_state_down", state_dbg, 3);
    goto(415); chk("vib_1100", motor_rpm, 1100);
    goto(420); chk("vib_1050", motor_rpm, 1050);
    goto(425); chk("vib_1000", motor_rpm, 1000);
    goto(426); chk("vib_at_limit", at_speed, 1);
    // pulse between ticks is ignored
    vibration_sensor = 1'b1;
    goto(427);
    vibration_sensor = 1'b0;
    goto(430); chk("vib_offtick_ignored", motor_rpm, 1000);
    // second backoff to 800
    vibration_sensor = 1'b1;
    goto(435); chk("vib2_950", motor_rpm, 950);
    vibration_sensor = 1'b0;
    goto(450); chk("vib2_800", motor_rpm, 800);
    // stop: ceiling restored on the tick after reaching zero
    target_rpm = 11'd0;
    goto(530); chk("vib_stop_0", motor_rpm, 0);
    goto(535); chk("vib_still_limited", vib_limited, 1);
    goto(536); chk("vib_restored", vib_limited, 0);
               chk("vib_idle", state_dbg, 0);

    // Door open at 800 (ramp to 800 proves ceiling is back above 800)
    target_rpm = 11'd800;
    goto(615); chk("door_pre_800", motor_rpm, 800);
    goto(616); chk("door_pre_at_speed", at_speed, 1);
    door_locked = 1'b0;
    goto(617); chk("door_fault_set", door_fault, 1);
               chk("door_brake_state", state_dbg, 4);
               chk("door_at_speed_off", at_speed, 0);
    goto(620); chk("brake_600", motor_rpm, 600);
    goto(625); chk("brake_400", motor_rpm, 400);
    goto(630); chk("brake_200", motor_rpm, 200);
    goto(635); chk("brake_0", motor_rpm, 0);
    goto(636); chk("brake_idle", state_dbg, 0);
               chk("fault_held", door_fault, 1);
    door_locked = 1'b1;
    goto(637); chk("fault_clear", door_fault, 0);

    // Reset mid-ramp
    goto(660); chk("mid_250", motor_rpm, 250);
               chk("mid_state", state_dbg, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rpm", motor_rpm, 0);
    chk("async_state", state_dbg, 0);
    chk("async_at_speed", at_speed, 0);
    @(posedge clk);
    #1 reset = 1'b0; now = 0;
    goto(4);   chk("phase_restart_hold", motor_rpm, 0);
    goto(5);   chk("phase_restart_tick", motor_rpm, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
